mem_stage: RTL and testbench

Memory-access stage of the five-stage MIPS pipeline, directly downstream of the execute stage. Latches the 154-bit EXE->MEM bus, performs load/store against a variable-latency data-memory port with byte-lane alignment, and presents a 118-bit MEM->WB bus to writeback. Owns its stage-valid register and the stall handshake toward EXE and WB.

---
 rtl/mem_stage_pkg.sv | 32 +++
 rtl/mem_align.sv | 41 ++++
 rtl/mem_stage.sv | 128 ++++++++++++
 tb/tb_mem_stage.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared widths, bus field offsets and FSM encoding for the memory stage.
package mem_stage_pkg;

    localparam int EXE_MEM_W = 154;
    localparam int MEM_WB_W  = 118;

    localparam int EM_CTL_LO   = 150;
    localparam int EM_CTL_HI   = 153;
    localparam int EM_SDATA_LO = 118;
    localparam int EM_RES_LO   = 86;
    localparam int EM_PASS_HI  = 85;
    localparam int EM_PASS_LO  = 38;
    localparam int EM_WEN      = 37;
    localparam int EM_WDEST_LO = 32;

    localparam int CTL_LOAD  = 3;
    localparam int CTL_STORE = 2;
    localparam int CTL_WORD  = 1;
    localparam int CTL_SIGN  = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } mem_state_e;

    function automatic logic is_mem_op(input logic [3:0] ctl);
        return ctl[CTL_LOAD] | ctl[CTL_STORE];
    endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering: store strobes/replication and load lane extract.
module mem_align (
    input  logic [1:0]  addr_lo,
    input  logic        ls_word,
    input  logic        lb_sign,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0] lane;

    always_comb begin
        wstrb = 4'h0;
        wdata = 32'h0;
        lane  = 8'h0;
        if (ls_word) begin
            wstrb = 4'hF;
            wdata = store_data;
        end else begin
            wstrb = 4'b0001 << addr_lo;
            wdata = {4{store_data[7:0]}};
        end
        unique case (addr_lo)
            2'd0: lane = rdata[7:0];
            2'd1: lane = rdata[15:8];
            2'd2: lane = rdata[23:16];
            2'd3: lane = rdata[31:24];
        endcase
    end

    always_comb begin
        load_data = rdata;
        if (!ls_word) begin
            load_data = lb_sign ? {{24{lane[7]}}, lane} : {24'h0, lane};
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: entry latch, data-memory handshake FSM, MEM->WB bus.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 EXE_over,
    input  logic [EXE_MEM_W-1:0] EXE_MEM_bus,
    output logic                 MEM_allow_in,
    input  logic                 WB_allow_in,
    output logic                 MEM_over,
    output logic [MEM_WB_W-1:0]  MEM_WB_bus,
    output logic [4:0]           MEM_wdest,
    output logic [31:0]          MEM_pc,
    output logic                 dm_req,
    output logic                 dm_wr,
    output logic [31:0]          dm_addr,
    output logic [3:0]           dm_wstrb,
    output logic [31:0]          dm_wdata,
    input  logic                 dm_ready,
    input  logic                 dm_rvalid,
    input  logic [31:0]          dm_rdata
);

    logic [EXE_MEM_W-1:0] bus_r;
    logic                 valid;
    mem_state_e           state;
    logic [31:0]          rdata_r;
    logic                 over_r;
    logic                 req_r;

    logic [3:0]  ctl;
    logic [31:0] store_data;
    logic [31:0] exe_result;
    logic [4:0]  rf_wdest;
    logic [31:0] pc;
    logic [31:0] load_data;
    logic [31:0] mem_result;
    logic        accept;
    logic        new_mem;

    assign ctl        = bus_r[EM_CTL_HI:EM_CTL_LO];
    assign store_data = bus_r[EM_SDATA_LO +: 32];
    assign exe_result = bus_r[EM_RES_LO +: 32];
    assign rf_wdest   = bus_r[EM_WDEST_LO +: 5];
    assign pc         = bus_r[31:0];

    assign MEM_allow_in = ~valid | (over_r & WB_allow_in);
    assign accept       = EXE_over & MEM_allow_in;
    assign new_mem      = is_mem_op(EXE_MEM_bus[EM_CTL_HI:EM_CTL_LO]);

    mem_align u_align (
        .addr_lo    (exe_result[1:0]),
        .ls_word    (ctl[CTL_WORD]),
        .lb_sign    (ctl[CTL_SIGN]),
        .store_data (store_data),
        .rdata      (dm_rdata),
        .wstrb      (dm_wstrb),
        .wdata      (dm_wdata),
        .load_data  (load_data)
    );

    // Accept is only possible when idle or retiring from DONE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            valid   <= 1'b0;
            bus_r   <= '0;
            rdata_r <= 32'h0;
            over_r  <= 1'b0;
            req_r   <= 1'b0;
        end else if (accept) begin
            bus_r <= EXE_MEM_bus;
            valid <= 1'b1;
            if (new_mem) begin
                state  <= S_REQ;
                req_r  <= 1'b1;
                over_r <= 1'b0;
            end else begin
                state  <= S_DONE;
                req_r  <= 1'b0;
                over_r <= 1'b1;
            end
        end else begin
            unique case (state)
                S_IDLE: ;
                S_REQ: begin
                    if (dm_ready) begin
                        req_r <= 1'b0;
                        if (ctl[CTL_STORE]) begin
                            state  <= S_DONE;
                            over_r <= 1'b1;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (dm_rvalid) begin
                        rdata_r <= load_data;
                        state   <= S_DONE;
                        over_r  <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (WB_allow_in) begin
                        state  <= S_IDLE;
                        valid  <= 1'b0;
                        over_r <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign mem_result = ctl[CTL_LOAD] ? rdata_r : exe_result;

    assign MEM_over   = over_r;
    assign MEM_WB_bus = {bus_r[EM_WEN], rf_wdest, mem_result,
                         bus_r[EM_PASS_HI:EM_PASS_LO], pc};
    assign MEM_wdest  = rf_wdest & {5{valid}};
    assign MEM_pc     = pc;

    assign dm_req  = req_r;
    assign dm_wr   = ctl[CTL_STORE];
    assign dm_addr = {exe_result[31:2], 2'b00};

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: vector table, scoreboard and hand-written corners.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         resetn;
    logic         EXE_over;
    logic [153:0] EXE_MEM_bus;
    logic         MEM_allow_in;
    logic         WB_allow_in;
    logic         MEM_over;
    logic [117:0] MEM_WB_bus;
    logic [4:0]   MEM_wdest;
    logic [31:0]  MEM_pc;
    logic         dm_req;
    logic         dm_wr;
    logic [31:0]  dm_addr;
    logic [3:0]   dm_wstrb;
    logic [31:0]  dm_wdata;
    logic         dm_ready;
    logic         dm_rvalid;
    logic [31:0]  dm_rdata;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk          (clk),
        .resetn       (resetn),
        .EXE_over     (EXE_over),
        .EXE_MEM_bus  (EXE_MEM_bus),
        .MEM_allow_in (MEM_allow_in),
        .WB_allow_in  (WB_allow_in),
        .MEM_over     (MEM_over),
        .MEM_WB_bus   (MEM_WB_bus),
        .MEM_wdest    (MEM_wdest),
        .MEM_pc       (MEM_pc),
        .dm_req       (dm_req),
        .dm_wr        (dm_wr),
        .dm_addr      (dm_addr),
        .dm_wstrb     (dm_wstrb),
        .dm_wdata     (dm_wdata),
        .dm_ready     (dm_ready),
        .dm_rvalid    (dm_rvalid),
        .dm_rdata     (dm_rdata)
    );

    typedef struct {
        logic [3:0]  ctl;
        logic [31:0] sdata;
        logic [31:0] addr;
        logic [4:0]  wdest;
        logic [31:0] pc;
        logic [31:0] rdata;
        logic [31:0] res;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        int          rdly;
        int          vdly;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int req_cnt = 0;
    logic [117:0] sb_q[$];
    vec_t tbl[10];

    function automatic logic [153:0] mk_bus(input vec_t v);
        return {v.ctl, v.sdata, v.addr, ~v.addr, 6'b101010, 8'h5A,
                2'b01, 1'b1, v.wdest, v.pc};
    endfunction

    function automatic logic [117:0] mk_wb(input vec_t v);
        return {1'b1, v.wdest, v.res, ~v.addr, 6'b101010, 8'h5A,
                2'b01, v.pc};
    endfunction

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Negative-edge sample point; also runs the WB-side scoreboard.
    task automatic neg();
        logic [117:0] e;
        @(negedge clk);
        if (dm_req && dm_ready) req_cnt++;
        if (resetn && MEM_over && WB_allow_in) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got %h expected none",
                         MEM_WB_bus);
            end else begin
                e = sb_q.pop_front();
                chk("wb_bus", MEM_WB_bus, e);
            end
        end
    endtask

    task automatic pos();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int  n;
        int  c0;
        bit  mem;
        bit  ld;
        mem = v.ctl[3] | v.ctl[2];
        ld  = v.ctl[3];
        c0  = req_cnt;
        n   = 0;
        while (!MEM_allow_in && n < 50) begin
            neg();
            pos();
            n++;
        end
        chk("allow_wait", MEM_allow_in, 1);
        EXE_MEM_bus = mk_bus(v);
        EXE_over = 1'b1;
        sb_q.push_back(mk_wb(v));
        neg();
        pos();
        EXE_over = 1'b0;
        if (!mem) begin
            neg();
            chk("alu_over", MEM_over, 1);
            chk("alu_wdest", MEM_wdest, v.wdest);
            pos();
        end else begin
            for (int i = 0; i <= v.rdly; i++) begin
                dm_ready = (i == v.rdly);
                neg();
                chk("req", dm_req, 1);
                chk("wr", dm_wr, !ld);
                chk("addr", dm_addr, {v.addr[31:2], 2'b00});
                chk("allow_busy", MEM_allow_in, 0);
                chk("over_early", MEM_over, 0);
                if (!ld) begin
                    chk("wstrb", dm_wstrb, v.wstrb);
                    chk("wdata", dm_wdata, v.wdata);
                end
                pos();
            end
            dm_ready = 1'b0;
            if (ld) begin
                for (int j = 0; j <= v.vdly; j++) begin
                    dm_rvalid = (j == v.vdly);
                    dm_rdata  = (j == v.vdly) ? v.rdata : 32'hDEAD_BEEF;
                    neg();
                    chk("req_drop", dm_req, 0);
                    chk("over_wait", MEM_over, 0);
                    pos();
                end
                dm_rvalid = 1'b0;
                dm_rdata  = 32'hDEAD_BEEF;
            end
            neg();
            chk("over_done", MEM_over, 1);
            chk("mem_wdest", MEM_wdest, v.wdest);
            pos();
            chk("one_req", req_cnt - c0, 1);
        end
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            neg();
            pos();
            n++;
        end
        chk("drain", sb_q.size(), 0);
    endtask

    initial begin
        vec_t a;
        vec_t b;
        vec_t c;
        vec_t l;

        tbl[0] = '{4'b0000, 32'h0, 32'h1234_5678, 5'd5, 32'h0040_0000,
                   32'h0, 32'h1234_5678, 4'h0, 32'h0, 0, 0};
        tbl[1] = '{4'b0100, 32'hDEAD_BEAB, 32'h0000_0103, 5'd6,
                   32'h0040_0004, 32'h0, 32'h0000_0103, 4'b1000,
                   32'hABAB_ABAB, 0, 0};
        tbl[2] = '{4'b0110, 32'hCAFE_F00D, 32'h0000_0200, 5'd7,
                   32'h0040_0008, 32'h0, 32'h0000_0200, 4'hF,
                   32'hCAFE_F00D, 1, 0};
        tbl[3] = '{4'b1001, 32'h0, 32'h0000_0302, 5'd8, 32'h0040_000C,
                   32'h0080_0000, 32'hFFFF_FF80, 4'h0, 32'h0, 0, 0};
        tbl[4] = '{4'b1000, 32'h0, 32'h0000_0302, 5'd9, 32'h0040_0010,
                   32'h0080_0000, 32'h0000_0080, 4'h0, 32'h0, 0, 1};
        tbl[5] = '{4'b1010, 32'h0, 32'h0000_0404, 5'd10, 32'h0040_0014,
                   32'h89AB_CDEF, 32'h89AB_CDEF, 4'h0, 32'h0, 3, 1};
        tbl[6] = '{4'b1001, 32'h0, 32'h0000_0500, 5'd11, 32'h0040_0018,
                   32'h1234_567F, 32'h0000_007F, 4'h0, 32'h0, 0, 0};
        tbl[7] = '{4'b1001, 32'h0, 32'h0000_0503, 5'd12, 32'h0040_001C,
                   32'h9A00_0000, 32'hFFFF_FF9A, 4'h0, 32'h0, 0, 0};
        tbl[8] = '{4'b0100, 32'h0000_0011, 32'h0000_0600, 5'd13,
                   32'h0040_0020, 32'h0, 32'h0000_0600, 4'b0001,
                   32'h1111_1111, 2, 0};
        tbl[9] = '{4'b1000, 32'h0, 32'h0000_0701, 5'd14, 32'h0040_0024,
                   32'h0000_C300, 32'h0000_00C3, 4'h0, 32'h0, 0, 0};

        resetn      = 1'b0;
        EXE_over    = 1'b0;
        EXE_MEM_bus = '0;
        WB_allow_in = 1'b1;
        dm_ready    = 1'b0;
        dm_rvalid   = 1'b0;
        dm_rdata    = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_over", MEM_over, 0);
        chk("rst_req", dm_req, 0);
        chk("rst_wdest", MEM_wdest, 0);
        chk("rst_pc", MEM_pc, 0);
        chk("rst_bus", MEM_WB_bus, 0);
        chk("rst_allow", MEM_allow_in, 1);
        resetn = 1'b1;
        neg();
        pos();

        for (int k = 0; k < 10; k++) run_vec(tbl[k]);

        a = '{4'b0000, 32'h0, 32'hAAAA_0001, 5'd20, 32'h0000_0800,
              32'h0, 32'hAAAA_0001, 4'h0, 32'h0, 0, 0};
        b = '{4'b0000, 32'h0, 32'hBBBB_0002, 5'd21, 32'h0000_0804,
              32'h0, 32'hBBBB_0002, 4'h0, 32'h0, 0, 0};
        c = '{4'b0000, 32'h0, 32'hCCCC_0003, 5'd22, 32'h0000_0808,
              32'h0, 32'hCCCC_0003, 4'h0, 32'h0, 0, 0};
        WB_allow_in = 1'b0;
        EXE_MEM_bus = mk_bus(a);
        EXE_over = 1'b1;
        sb_q.push_back(mk_wb(a));
        neg();
        pos();
        EXE_MEM_bus = mk_bus(b);
        for (int k = 0; k < 2; k++) begin
            neg();
            chk("hold_over", MEM_over, 1);
            chk("hold_allow", MEM_allow_in, 0);
            chk("hold_bus", MEM_WB_bus, mk_wb(a));
            pos();
        end
        WB_allow_in = 1'b1;
        sb_q.push_back(mk_wb(b));
        neg();
        chk("rel_allow", MEM_allow_in, 1);
        pos();
        EXE_MEM_bus = mk_bus(c);
        sb_q.push_back(mk_wb(c));
        neg();
        chk("b2b_pc", MEM_pc, b.pc);
        chk("b2b_over", MEM_over, 1);
        pos();
        EXE_over = 1'b0;
        neg();
        chk("b2b_over2", MEM_over, 1);
        pos();
        neg();
        chk("idle_over", MEM_over, 0);
        chk("idle_wdest", MEM_wdest, 0);
        pos();
        chk("bp_drain", sb_q.size(), 0);

        l = '{4'b1010, 32'h0, 32'h0000_0900, 5'd23, 32'h0000_0900,
              32'h5555_6666, 32'h5555_6666, 4'h0, 32'h0, 0, 0};
        EXE_MEM_bus = mk_bus(l);
        EXE_over = 1'b1;
        neg();
        pos();
        EXE_over = 1'b0;
        dm_ready = 1'b1;
        neg();
        chk("ab_req", dm_req, 1);
        pos();
        dm_ready = 1'b0;
        neg();
        chk("ab_wait_req", dm_req, 0);
        chk("ab_wait_over", MEM_over, 0);
        pos();
        #2;
        resetn = 1'b0;
        #1;
        chk("ab_over", MEM_over, 0);
        chk("ab_dmreq", dm_req, 0);
        chk("ab_wdest", MEM_wdest, 0);
        chk("ab_pc", MEM_pc, 0);
        chk("ab_bus", MEM_WB_bus, 0);
        chk("ab_allow", MEM_allow_in, 1);
        neg();
        pos();
        resetn = 1'b1;
        dm_rvalid = 1'b1;
        dm_rdata  = 32'h1111_2222;
        neg();
        chk("stale_over", MEM_over, 0);
        pos();
        dm_rvalid = 1'b0;
        neg();
        chk("stale_over2", MEM_over, 0);
        chk("stale_req", dm_req, 0);
        chk("stale_bus", MEM_WB_bus, 0);
        chk("stale_allow", MEM_allow_in, 1);
        pos();

        run_vec(tbl[0]);
        run_vec(tbl[3]);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
